// File: rtl/snake_motion_if.sv
// rtl/snake_motion_if.sv - control, status and segment read bundle for snake_motion_ctrl
interface snake_motion_if;
    logic       enable;
    logic       pause;
    logic       btn_l;
    logic       btn_r;
    logic       btn_u;
    logic       btn_d;
    logic       grow;
    logic [5:0] rd_idx;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [6:0] length;
    logic [2:0] state;
    logic       step_strobe;
    logic       game_over;

    modport master (
        output enable, pause, btn_l, btn_r, btn_u, btn_d, grow, rd_idx,
        input  rd_x, rd_y, head_x, head_y, length, state, step_strobe, game_over
    );

    modport slave (
        input  enable, pause, btn_l, btn_r, btn_u, btn_d, grow, rd_idx,
        output rd_x, rd_y, head_x, head_y, length, state, step_strobe, game_over
    );
endinterface

// File: rtl/snake_motion_ctrl.sv
// rtl/snake_motion_ctrl.sv - snake movement, growth, collision detection and game FSM
module snake_motion_ctrl #(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 4,
    parameter int STEP     = 5,
    parameter int SEG      = 10,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = 100,
    parameter int TICK_DIV = 1600000
) (
    input  logic         clk_25M,
    input  logic         reset,
    snake_motion_if.slave sif
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [9:0] PARK_X = 10'd700;
    localparam logic [9:0] PARK_Y = 10'd500;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_RUN = 3'd2,
        ST_SCAN = 3'd3, ST_PAUSE = 3'd4, ST_OVER = 3'd5
    } state_t;
    typedef enum logic [2:0] {
        DIR_NONE = 3'd0, DIR_L = 3'd1, DIR_R = 3'd2, DIR_U = 3'd3, DIR_D = 3'd4
    } dir_t;

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d, dir_next_q, dir_next_d, req;
    logic [TW-1:0] tick_q, tick_d;
    logic          grow_q, grow_d;
    logic [6:0]    len_q, len_d, new_len;
    logic [5:0]    scan_q, scan_d;
    logic          strobe_q, strobe_d;
    logic          over_q, over_d;
    logic [9:0]    seg_x_q [MAX_LEN];
    logic [9:0]    seg_y_q [MAX_LEN];
    logic [9:0]    seg_x_d [MAX_LEN];
    logic [9:0]    seg_y_d [MAX_LEN];
    logic [9:0]    nx, ny;
    logic [10:0]   wx, wy;
    logic          req_ok, live, wall;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dir_next_d = dir_next_q;
        tick_d     = tick_q;
        grow_d     = grow_q;
        len_d      = len_q;
        scan_d     = scan_q;
        strobe_d   = 1'b0;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;

        // Highest-priority button wins; a reversing request is dropped, not demoted.
        if (sif.btn_l)      req = DIR_L;
        else if (sif.btn_r) req = DIR_R;
        else if (sif.btn_u) req = DIR_U;
        else if (sif.btn_d) req = DIR_D;
        else                req = DIR_NONE;
        req_ok = (req != DIR_NONE) &&
                 !((req == DIR_L && dir_q == DIR_R) || (req == DIR_R && dir_q == DIR_L) ||
                   (req == DIR_U && dir_q == DIR_D) || (req == DIR_D && dir_q == DIR_U));
        live = (state_q == ST_WAIT) || (state_q == ST_RUN) ||
               (state_q == ST_SCAN) || (state_q == ST_PAUSE);
        if (live && req_ok) dir_next_d = req;
        if (live && sif.grow) grow_d = 1'b1;

        nx = seg_x_q[0];
        ny = seg_y_q[0];
        case (dir_next_q)
            DIR_L:   nx = seg_x_q[0] - 10'(STEP);
            DIR_R:   nx = seg_x_q[0] + 10'(STEP);
            DIR_U:   ny = seg_y_q[0] - 10'(STEP);
            DIR_D:   ny = seg_y_q[0] + 10'(STEP);
            default: ;
        endcase
        wx   = {1'b0, nx};
        wy   = {1'b0, ny};
        wall = (wx < 11'd11) || (wx + 11'(SEG) > 11'd629) ||
               (wy < 11'd11) || (wy + 11'(SEG) > 11'd469);
        // A grow pulse on the terminal tick itself still counts for this step.
        new_len = ((grow_q || sif.grow) && len_q < 7'(MAX_LEN)) ? len_q + 7'd1 : len_q;

        case (state_q)
            ST_WAIT: begin
                if (req_ok) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end
            end
            ST_RUN: begin
                if (sif.pause) begin
                    state_d = ST_PAUSE;
                end else if (tick_q == TW'(TICK_DIV - 1)) begin
                    tick_d = '0;
                    dir_d  = dir_next_q;
                    for (int i = 1; i < MAX_LEN; i++) begin
                        if (i < int'(new_len)) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                    end
                    seg_x_d[0] = nx;
                    seg_y_d[0] = ny;
                    len_d      = new_len;
                    grow_d     = 1'b0;
                    strobe_d   = 1'b1;
                    scan_d     = 6'd1;
                    state_d    = wall ? ST_OVER : ST_SCAN;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_SCAN: begin
                if (seg_x_q[scan_q] == seg_x_q[0] && seg_y_q[scan_q] == seg_y_q[0])
                    state_d = ST_OVER;
                else if (7'(scan_q) == len_q - 7'd1)
                    state_d = ST_RUN;
                else
                    scan_d = scan_q + 6'd1;
            end
            ST_PAUSE: begin
                if (!sif.pause) state_d = ST_RUN;
            end
            default: ;
        endcase

        if (!sif.enable || state_q == ST_IDLE) begin
            state_d    = (sif.enable && state_q == ST_IDLE) ? ST_WAIT : ST_IDLE;
            dir_d      = DIR_NONE;
            dir_next_d = DIR_NONE;
            tick_d     = '0;
            grow_d     = 1'b0;
            len_d      = 7'(INIT_LEN);
            scan_d     = 6'd1;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = PARK_X;
                seg_y_d[i] = PARK_Y;
            end
            seg_x_d[0] = 10'(INIT_X);
            seg_y_d[0] = 10'(INIT_Y);
        end
        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_25M or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_NONE;
            dir_next_q <= DIR_NONE;
            tick_q     <= '0;
            grow_q     <= 1'b0;
            len_q      <= 7'(INIT_LEN);
            scan_q     <= 6'd1;
            strobe_q   <= 1'b0;
            over_q     <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i == 0) ? 10'(INIT_X) : PARK_X;
                seg_y_q[i] <= (i == 0) ? 10'(INIT_Y) : PARK_Y;
            end
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            dir_next_q <= dir_next_d;
            tick_q     <= tick_d;
            grow_q     <= grow_d;
            len_q      <= len_d;
            scan_q     <= scan_d;
            strobe_q   <= strobe_d;
            over_q     <= over_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
        end
    end

    assign sif.rd_x        = seg_x_q[sif.rd_idx];
    assign sif.rd_y        = seg_y_q[sif.rd_idx];
    assign sif.head_x      = seg_x_q[0];
    assign sif.head_y      = seg_y_q[0];
    assign sif.length      = len_q;
    assign sif.state       = state_q;
    assign sif.step_strobe = strobe_q;
    assign sif.game_over   = over_q;
endmodule
